// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer.
//   NUM_CH  : number of decoder channels scanned (3-to-8 decoder)
//   SEL_W   : width of the channel select code
//   state_e : sequencer FSM states
package decoder_scan_sequencer_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_scan_sequencer_scan_next_channel.sv
// Combinational channel search for the scan sequencer.
//   mask_i       : channel enable mask
//   cur_i        : currently presented channel
//   from_start_i : 1 = search from index 0, 0 = search strictly above cur_i
//   next_o       : lowest qualifying enabled channel
//   found_o      : a qualifying channel exists
module scan_next_channel
  import decoder_scan_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              from_start_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              found_o
);

  // Walk from the top down so the lowest qualifying index is the last write.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (from_start_i || (SEL_W'(i) > cur_i))) begin
        next_o  = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer feeding a 3-to-8 decoder. Steps through the enabled
// channels of a latched mask; each channel gets BLANK_CYCLES with the
// decoder disabled after the select changes, then DWELL_CYCLES enabled.
//   clk, rst       : clock, asynchronous active-high reset
//   start_i        : begin a frame (honoured only when idle)
//   stop_i         : abort the scan, wins over start
//   continuous_i   : relatch the mask and rescan after each frame
//   ch_mask_i      : channel enable mask, bit n enables channel n
//   sel_o          : channel code to the decoder
//   sel_valid_o    : decoder enable, high only while dwelling
//   frame_done_o   : one-cycle pulse after the last channel's dwell
//   busy_o         : sequencer not idle
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              continuous_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              sel_valid_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  // Guarded so a zero blanking setting does not produce a negative constant;
  // BLANK is never entered in that case.
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                sel_valid_q, sel_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;

  state_e              first_ph;
  logic [SEL_W-1:0]    adv_next, rst_next;
  logic                adv_found, rst_found;

  // Phase entered whenever a new channel is selected.
  assign first_ph = (BLANK_CYCLES == 0) ? DWELL : BLANK;

  // Next channel within the current frame: above sel in the latched mask.
  scan_next_channel u_adv (
    .mask_i       (mask_q),
    .cur_i        (sel_q),
    .from_start_i (1'b0),
    .next_o       (adv_next),
    .found_o      (adv_found)
  );

  // First channel of a new frame: lowest set bit of the live mask input.
  scan_next_channel u_first (
    .mask_i       (ch_mask_i),
    .cur_i        (sel_q),
    .from_start_i (1'b1),
    .next_o       (rst_next),
    .found_o      (rst_found)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q + CNT_W'(1);
    mask_d       = mask_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i && !stop_i && rst_found) begin
          mask_d  = ch_mask_i;
          sel_d   = rst_next;
          state_d = first_ph;
        end
      end
      BLANK: begin
        if (stop_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = DWELL;
          cnt_d   = '0;
        end
      end
      DWELL: begin
        if (stop_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (adv_found) begin
            sel_d   = adv_next;
            state_d = first_ph;
          end else begin
            // Frame complete. In continuous mode the new frame's first
            // blanking overlaps the frame_done pulse.
            frame_done_d = 1'b1;
            if (continuous_i) begin
              mask_d = ch_mask_i;
            end
            if (continuous_i && rst_found) begin
              sel_d   = rst_next;
              state_d = first_ph;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sel_valid_d = (state_d == DWELL);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
    end
  end

  assign sel_o        = sel_q;
  assign sel_valid_o  = sel_valid_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: instance 0 uses default timing
// (blank 1, dwell 4), instance 1 uses blank 0, dwell 1. Both share stimulus.
// The reference model tracks each frame as a mask plus a cycle position and
// derives sel / sel_valid from that position arithmetically.
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic [7:0] mask = 8'h00;

  logic [2:0] sel_w  [2];
  logic       sv_w   [2];
  logic       fd_w   [2];
  logic       busy_w [2];

  always #5 clk = ~clk;

  decoder_scan_sequencer dut_a (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .continuous_i(cont),
    .ch_mask_i(mask), .sel_o(sel_w[0]), .sel_valid_o(sv_w[0]),
    .frame_done_o(fd_w[0]), .busy_o(busy_w[0])
  );

  decoder_scan_sequencer #(.DWELL_CYCLES(1), .BLANK_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .continuous_i(cont),
    .ch_mask_i(mask), .sel_o(sel_w[1]), .sel_valid_o(sv_w[1]),
    .frame_done_o(fd_w[1]), .busy_o(busy_w[1])
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         BL [2] = '{1, 0};
  int         DW [2] = '{4, 1};
  bit         mb   [2];
  int         mpos [2];
  logic [7:0] mfm  [2];
  logic [2:0] msel [2];
  bit         msv  [2];
  bit         mfd  [2];

  function automatic logic [2:0] nth_set(input logic [7:0] m, input int n);
    int k = 0;
    nth_set = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (k == n) nth_set = 3'(i);
        k++;
      end
    end
  endfunction

  task automatic show(input int m);
    int p = BL[m] + DW[m];
    msel[m] = nth_set(mfm[m], mpos[m] / p);
    msv[m]  = (mpos[m] % p) >= BL[m];
  endtask

  task automatic step(input int m);
    int len = $countones(mfm[m]) * (BL[m] + DW[m]);
    mfd[m] = 1'b0;
    if (mb[m]) begin
      if (stop) begin
        mb[m] = 1'b0; msv[m] = 1'b0;
      end else if (mpos[m] + 1 < len) begin
        mpos[m]++; show(m);
      end else begin
        mfd[m] = 1'b1;
        if (cont && mask != 8'h00) begin
          mfm[m] = mask; mpos[m] = 0; show(m);
        end else begin
          mb[m] = 1'b0; msv[m] = 1'b0;
        end
      end
    end else if (start && !stop && mask != 8'h00) begin
      mfm[m] = mask; mpos[m] = 0; mb[m] = 1'b1; show(m);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        mb[m] = 1'b0; mpos[m] = 0; mfm[m] = 8'h00;
        msel[m] = 3'd0; msv[m] = 1'b0; mfd[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) step(m);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("sel%0d", m),  sel_w[m],  msel[m]);
        chk($sformatf("sv%0d", m),   sv_w[m],   msv[m]);
        chk($sformatf("fd%0d", m),   fd_w[m],   mfd[m]);
        chk($sformatf("busy%0d", m), busy_w[m], mb[m]);
      end
      // Enabled decoder output must always be a channel of the frame mask.
      chk("sv_in_mask", int'(!sv_w[0] || mfm[0][sel_w[0]]), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input logic [7:0] mk, output int na, output int nb);
    @(negedge clk); mask = mk; cont = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("first_busy", busy_w[0], 1);
    chk("first_sv_a", sv_w[0], 0);
    chk("first_sv_b", sv_w[1], 1);
    na = 0; nb = 0;
    for (int n = 1; n <= 80; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 2) chk("second_sv_a", sv_w[0], 1);
      if (fd_w[0] && na == 0) begin
        na = n;
        chk("fd_busy_fall", busy_w[0], 0);
      end
      if (fd_w[1] && nb == 0) nb = n;
    end
  endtask

  task automatic wait_dwell(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = sv_w[0] && (sel_w[0] == s);
    end
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = fd_w[0];
    end
  endtask

  initial begin
    int na, nb;
    bit ok;

    repeat (3) @(negedge clk);
    chk("rst_sel", sel_w[0], 0);
    chk("rst_sv", sv_w[0], 0);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_fd", fd_w[0], 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full mask, single frame: 8 x 5 cycles, and 8 x 1 for the fast instance.
    run_frame(8'hFF, na, nb);
    chk("s1_len_a", na, 41);
    chk("s1_len_b", nb, 9);

    // Sparse mask 2,5,7.
    run_frame(8'hA4, na, nb);
    chk("s2_len_a", na, 16);
    chk("s2_len_b", nb, 4);

    // Continuous, mask edited mid-frame takes effect only at relatch.
    @(negedge clk); mask = 8'h81; cont = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    mask = 8'h10;
    wait_fd(ok);
    chk("s3_fd1_seen", ok, 1);
    chk("s3_relatch_sel", sel_w[0], 4);
    chk("s3_relatch_busy", busy_w[0], 1);
    mask = 8'h00;
    wait_fd(ok);
    chk("s3_fd2_seen", ok, 1);
    chk("s3_idle_busy", busy_w[0], 0);
    cont = 1'b0;
    repeat (3) @(negedge clk);
    chk("s3_idle_busy_b", busy_w[1], 0);

    // Stop in the third dwell cycle of channel 3.
    @(negedge clk); mask = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_dwell(3'd3, ok);
    chk("s4_reach_ch3", ok, 1);
    repeat (2) @(negedge clk);
    chk("s4_third_dwell", sv_w[0], 1);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("s4_stop_busy", busy_w[0], 0);
    chk("s4_stop_sv", sv_w[0], 0);
    chk("s4_stop_fd", fd_w[0], 0);
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("s4_stop_beats_start", busy_w[0], 0);

    // Asynchronous reset mid-dwell.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_dwell(3'd2, ok);
    chk("s5_reach_ch2", ok, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("s5_async_sel", sel_w[0], 0);
    chk("s5_async_sv", sv_w[0], 0);
    chk("s5_async_busy", busy_w[0], 0);
    chk("s5_async_busy_b", busy_w[1], 0);
    @(negedge clk); rst = 1'b0;
    run_frame(8'hFF, na, nb);
    chk("s5_len_a", na, 41);
    chk("s5_len_b", nb, 9);

    // Zero-blank instance steps every cycle with the enable held high.
    @(negedge clk); mask = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("s6_sel_b", sel_w[1], i);
      chk("s6_sv_b", sv_w[1], 1);
    end
    repeat (45) @(negedge clk);
    mask = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("s6_zero_mask_a", busy_w[0], 0);
    chk("s6_zero_mask_b", busy_w[1], 0);

    // Randomized traffic against the model.
    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      cont  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
    end
    @(negedge clk); start = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
